fx_key_ctrl: RTL and testbench

Keyboard-driven controller for the VGA pixel-effects stage. It consumes the decoded PS/2 scancode stream and runs a make/break/extended decode FSM with auto-repeat suppression. It holds the pending effect configuration (flash, per-channel invert, blink rate) and commits it to the effects datapath only at frame start, so settings never change mid-frame. It also generates the blink phase and realigns it to frame boundaries.

---
 rtl/fx_pkg.sv | 50 +++++
 rtl/fx_blink_gen.sv | 52 +++++
 rtl/fx_key_ctrl.sv | 149 ++++++++++++++
 tb/tb_fx_key_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared definitions for the keyboard-driven effects controller:
// scancodes, decode FSM states and the command set derived from make codes.
package fx_pkg;

  localparam logic [7:0] SC_E0  = 8'hE0;
  localparam logic [7:0] SC_F0  = 8'hF0;
  localparam logic [7:0] SC_AA  = 8'hAA;
  localparam logic [7:0] SC_F   = 8'h2B;
  localparam logic [7:0] SC_R   = 8'h2D;
  localparam logic [7:0] SC_1   = 8'h16;
  localparam logic [7:0] SC_2   = 8'h1E;
  localparam logic [7:0] SC_3   = 8'h26;
  localparam logic [7:0] SC_S   = 8'h1B;
  localparam logic [7:0] SC_ESC = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } key_state_e;

  // The command value doubles as the index of that key's held bit.
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_FLASH,
    CMD_INV_ALL,
    CMD_INV_R,
    CMD_INV_G,
    CMD_INV_B,
    CMD_RATE,
    CMD_CLR
  } cmd_e;

  function automatic cmd_e sc_to_cmd(input logic [7:0] sc);
    cmd_e cmd;
    case (sc)
      SC_F:    cmd = CMD_FLASH;
      SC_R:    cmd = CMD_INV_ALL;
      SC_1:    cmd = CMD_INV_R;
      SC_2:    cmd = CMD_INV_G;
      SC_3:    cmd = CMD_INV_B;
      SC_S:    cmd = CMD_RATE;
      SC_ESC:  cmd = CMD_CLR;
      default: cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/fx_blink_gen.sv
// Blink phase generator: a down-counter whose reload value halves per rate
// step; the raw phase toggles each time the counter expires.
module fx_blink_gen
  import fx_pkg::*;
#(
  parameter int BLINK_BASE = 25000000,
  parameter int CNT_W      = 26
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_rate,
  input  logic       i_reload,
  output logic       o_phase
);

  localparam logic [CNT_W-1:0] LOAD0 = CNT_W'(BLINK_BASE - 1);
  localparam logic [CNT_W-1:0] LOAD1 = CNT_W'((BLINK_BASE >> 1) - 1);
  localparam logic [CNT_W-1:0] LOAD2 = CNT_W'((BLINK_BASE >> 2) - 1);
  localparam logic [CNT_W-1:0] LOAD3 = CNT_W'((BLINK_BASE >> 3) - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic [CNT_W-1:0] w_load;

  always_comb begin
    w_load = LOAD0;
    case (i_rate)
      2'd1:    w_load = LOAD1;
      2'd2:    w_load = LOAD2;
      2'd3:    w_load = LOAD3;
      default: w_load = LOAD0;
    endcase
  end

  // A forced reload restarts the half-period without disturbing the phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= LOAD0;
      r_phase <= 1'b0;
    end else if (i_reload) begin
      r_cnt   <= w_load;
    end else if (r_cnt == '0) begin
      r_cnt   <= w_load;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/fx_key_ctrl.sv
// PS/2 command decoder for the pixel-effects stage; pending settings are
// committed only at frame start so the picture never changes mid-frame.
module fx_key_ctrl
  import fx_pkg::*;
#(
  parameter int BLINK_BASE = 25000000,
  parameter int CNT_W      = 26
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_scancode,
  input  logic       i_flagkey,
  input  logic [9:0] i_hpos,
  input  logic [8:0] i_vpos,
  output logic       o_flash_en,
  output logic [2:0] o_inv_mask,
  output logic [1:0] o_rate_sel,
  output logic       o_blink_on,
  output logic       o_frame_start
);

  key_state_e r_state;
  key_state_e w_state_next;
  cmd_e       w_make;
  cmd_e       w_brk;
  logic       w_do_cmd;
  logic [7:0] r_held;

  logic       r_p_flash;
  logic [2:0] r_p_inv;
  logic [1:0] r_p_rate;

  logic       r_flash;
  logic [2:0] r_inv;
  logic [1:0] r_rate;
  logic       r_blink;
  logic       r_frame_start;

  logic [1:0] w_rate_eff;
  logic       w_reload;
  logic       w_phase_raw;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // BAT completion resynchronises the decoder from any state.
  always_comb begin
    w_state_next = r_state;
    w_make       = CMD_NONE;
    w_brk        = CMD_NONE;
    if (i_flagkey) begin
      if (i_scancode == SC_AA) begin
        w_state_next = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_scancode == SC_E0)      w_state_next = ST_EXT;
            else if (i_scancode == SC_F0) w_state_next = ST_BRK;
            else                          w_make = sc_to_cmd(i_scancode);
          end
          ST_EXT:  w_state_next = (i_scancode == SC_F0) ? ST_EXT_BRK : ST_IDLE;
          ST_BRK: begin
            w_brk        = sc_to_cmd(i_scancode);
            w_state_next = ST_IDLE;
          end
          default: w_state_next = ST_IDLE;
        endcase
      end
    end
  end

  assign w_do_cmd = (w_make != CMD_NONE) && !r_held[w_make];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_held <= '0;
    end else if (w_do_cmd) begin
      if (w_make == CMD_CLR) r_held <= '0;
      else                   r_held[w_make] <= 1'b1;
    end else if (w_brk != CMD_NONE) begin
      r_held[w_brk] <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p_flash <= 1'b0;
      r_p_inv   <= '0;
      r_p_rate  <= '0;
    end else if (w_do_cmd) begin
      case (w_make)
        CMD_FLASH:   r_p_flash <= ~r_p_flash;
        CMD_INV_ALL: r_p_inv   <= r_p_inv ^ 3'b111;
        CMD_INV_R:   r_p_inv   <= r_p_inv ^ 3'b100;
        CMD_INV_G:   r_p_inv   <= r_p_inv ^ 3'b010;
        CMD_INV_B:   r_p_inv   <= r_p_inv ^ 3'b001;
        CMD_RATE:    r_p_rate  <= r_p_rate + 2'd1;
        CMD_CLR: begin
          r_p_flash <= 1'b0;
          r_p_inv   <= '0;
          r_p_rate  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Commit samples pending before any same-cycle key update lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_start <= 1'b0;
      r_flash       <= 1'b0;
      r_inv         <= '0;
      r_rate        <= '0;
      r_blink       <= 1'b0;
    end else begin
      r_frame_start <= (i_hpos == '0) && (i_vpos == '0);
      if (r_frame_start) begin
        r_flash <= r_p_flash;
        r_inv   <= r_p_inv;
        r_rate  <= r_p_rate;
        r_blink <= w_phase_raw;
      end
    end
  end

  assign w_rate_eff = r_frame_start ? r_p_rate : r_rate;
  assign w_reload   = r_frame_start && (r_p_rate != r_rate);

  fx_blink_gen #(
    .BLINK_BASE(BLINK_BASE),
    .CNT_W     (CNT_W)
  ) u_blink (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rate  (w_rate_eff),
    .i_reload(w_reload),
    .o_phase (w_phase_raw)
  );

  assign o_flash_en    = r_flash;
  assign o_inv_mask    = r_inv;
  assign o_rate_sel    = r_rate;
  assign o_blink_on    = r_blink;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_fx_key_ctrl.sv
// Bench for fx_key_ctrl: a behavioural model pushes each frame's expected
// commit into a scoreboard queue that is popped once the DUT has committed.
module tb_fx_key_ctrl;

  localparam int TB_BASE  = 16;
  localparam int TB_CNT_W = 5;
  localparam int H        = 20;
  localparam int V        = 3;
  localparam int FRAME    = H * V;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] scancode;
  logic       flagkey;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       flashEn;
  logic [2:0] invMask;
  logic [1:0] rateSel;
  logic       blinkOn;
  logic       frameStart;

  always #5 clk = ~clk;

  fx_key_ctrl #(
    .BLINK_BASE(TB_BASE),
    .CNT_W     (TB_CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_scancode   (scancode),
    .i_flagkey    (flagkey),
    .i_hpos       (hpos),
    .i_vpos       (vpos),
    .o_flash_en   (flashEn),
    .o_inv_mask   (invMask),
    .o_rate_sel   (rateSel),
    .o_blink_on   (blinkOn),
    .o_frame_start(frameStart)
  );

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Raster generator: positions advance just after each rising edge.
  initial begin
    hpos = '0;
    vpos = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hpos == 10'(H - 1)) begin
        hpos = '0;
        vpos = (vpos == 9'(V - 1)) ? 9'd0 : vpos + 9'd1;
      end else begin
        hpos = hpos + 10'd1;
      end
    end
  end

  // Reference model state
  int         mState;
  logic [7:0] mHeld;
  logic       mPflash;
  logic [2:0] mPinv;
  logic [1:0] mPrate;
  logic [1:0] mRate;
  logic       mFs;
  logic       mBlink;
  logic       mPhase;
  int         mCnt;
  logic [5:0] sbQueue[$];
  bit         popPending;

  function automatic int keyIdx(input logic [7:0] b);
    case (b)
      8'h2B:   return 1;
      8'h2D:   return 2;
      8'h16:   return 3;
      8'h1E:   return 4;
      8'h26:   return 5;
      8'h1B:   return 6;
      8'h76:   return 7;
      default: return 0;
    endcase
  endfunction

  function automatic int loadValue(input logic [1:0] r);
    return (TB_BASE >> r) - 1;
  endfunction

  task automatic modelMake(input logic [7:0] b);
    int k;
    k = keyIdx(b);
    if (k != 0 && !mHeld[k]) begin
      mHeld[k] = 1'b1;
      case (k)
        1: mPflash = ~mPflash;
        2: mPinv   = mPinv ^ 3'b111;
        3: mPinv   = mPinv ^ 3'b100;
        4: mPinv   = mPinv ^ 3'b010;
        5: mPinv   = mPinv ^ 3'b001;
        6: mPrate  = mPrate + 2'd1;
        default: begin
          mPflash = 1'b0;
          mPinv   = '0;
          mPrate  = '0;
          mHeld   = '0;
        end
      endcase
    end
  endtask

  // Each negedge: compare against the model, then advance it past the next edge.
  always @(negedge clk) begin
    logic [5:0] exp;
    logic       commit;
    logic [1:0] newRate;
    int         k;
    if (!rst_n) begin
      mState = 0; mHeld = '0; mPflash = 0; mPinv = '0; mPrate = '0;
      mRate = '0; mFs = 0; mBlink = 0; mPhase = 0; mCnt = TB_BASE - 1;
      sbQueue.delete();
      popPending = 0;
    end else begin
      checkOutput("frame_start", 32'(frameStart), 32'(mFs));
      checkOutput("blink_on", 32'(blinkOn), 32'(mBlink));
      if (popPending) begin
        popPending = 0;
        checkOutput("sb_not_empty", 32'(sbQueue.size() != 0), 32'd1);
        if (sbQueue.size() != 0) begin
          exp = sbQueue.pop_front();
          checkOutput("commit_flash", 32'(flashEn), 32'(exp[5]));
          checkOutput("commit_inv", 32'(invMask), 32'(exp[4:2]));
          checkOutput("commit_rate", 32'(rateSel), 32'(exp[1:0]));
        end
      end
      commit = mFs;
      if (commit) begin
        sbQueue.push_back({mPflash, mPinv, mPrate});
        popPending = 1;
        mBlink = mPhase;
      end
      newRate = commit ? mPrate : mRate;
      if (commit && mPrate != mRate) begin
        mCnt = loadValue(newRate);
      end else if (mCnt == 0) begin
        mCnt   = loadValue(newRate);
        mPhase = ~mPhase;
      end else begin
        mCnt = mCnt - 1;
      end
      mRate = newRate;
      mFs   = (hpos == 10'd0) && (vpos == 9'd0);
      if (flagkey) begin
        if (scancode == 8'hAA) begin
          mState = 0;
        end else begin
          case (mState)
            0: begin
              if (scancode == 8'hE0)      mState = 1;
              else if (scancode == 8'hF0) mState = 2;
              else                        modelMake(scancode);
            end
            1: mState = (scancode == 8'hF0) ? 3 : 0;
            2: begin
              k = keyIdx(scancode);
              if (k != 0) mHeld[k] = 1'b0;
              mState = 0;
            end
            default: mState = 0;
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic driveByte(input logic [7:0] b);
    scancode = b;
    flagkey  = 1'b1;
    tick();
    flagkey  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    driveByte(b);
    tick();
    tick();
  endtask

  task automatic waitRaster(input string tag, input int h, input int v);
    bit found;
    found = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      tick();
      if (hpos == 10'(h) && vpos == 9'(v)) begin
        found = 1;
        break;
      end
    end
    checkOutput(tag, 32'(found), 32'd1);
  endtask

  task automatic waitCommit();
    waitRaster("wait_commit", 2, 0);
  endtask

  task automatic waitMidFrame();
    waitRaster("wait_mid", 10, 1);
  endtask

  initial begin
    int   pulses;
    int   t1, t2, nChanges;
    logic prevPhase;
    rst_n    = 1'b0;
    flagkey  = 1'b0;
    scancode = '0;
    repeat (3) tick();
    checkOutput("rst_flash", 32'(flashEn), 32'd0);
    checkOutput("rst_inv", 32'(invMask), 32'd0);
    checkOutput("rst_rate", 32'(rateSel), 32'd0);
    checkOutput("rst_blink", 32'(blinkOn), 32'd0);
    checkOutput("rst_fs", 32'(frameStart), 32'd0);
    rst_n = 1'b1;

    pulses = 0;
    repeat (2 * FRAME) begin
      tick();
      if (frameStart) pulses++;
    end
    checkOutput("idle_fs_pulses", 32'(pulses), 32'd2);
    checkOutput("idle_flash", 32'(flashEn), 32'd0);
    checkOutput("idle_inv", 32'(invMask), 32'd0);

    waitMidFrame();
    driveByte(8'h2B);
    checkOutput("p_flash_after_strobe", 32'(dut.r_p_flash), 32'd1);
    checkOutput("flash_before_commit", 32'(flashEn), 32'd0);
    applyStimulus(8'hF0);
    applyStimulus(8'h2B);
    waitCommit();
    checkOutput("flash_committed", 32'(flashEn), 32'd1);

    waitMidFrame();
    applyStimulus(8'h2D);
    applyStimulus(8'h2D);
    applyStimulus(8'h2D);
    applyStimulus(8'hF0);
    applyStimulus(8'h2D);
    waitCommit();
    checkOutput("inv_held_all", 32'(invMask), 32'd7);

    waitMidFrame();
    applyStimulus(8'h76);
    applyStimulus(8'hF0);
    applyStimulus(8'h76);
    waitCommit();
    checkOutput("esc_flash", 32'(flashEn), 32'd0);
    checkOutput("esc_inv", 32'(invMask), 32'd0);

    waitMidFrame();
    applyStimulus(8'h1E);
    applyStimulus(8'hF0);
    applyStimulus(8'h1E);
    waitCommit();
    checkOutput("inv_g", 32'(invMask), 32'd2);
    waitMidFrame();
    applyStimulus(8'h2D);
    applyStimulus(8'hF0);
    applyStimulus(8'h2D);
    waitCommit();
    checkOutput("inv_g_then_all", 32'(invMask), 32'd5);

    waitMidFrame();
    applyStimulus(8'h1B);
    applyStimulus(8'hF0);
    applyStimulus(8'h1B);
    applyStimulus(8'h1B);
    applyStimulus(8'hF0);
    applyStimulus(8'h1B);
    waitCommit();
    checkOutput("rate_two", 32'(rateSel), 32'd2);
    prevPhase = dut.w_phase_raw;
    nChanges  = 0;
    t1 = 0;
    t2 = 0;
    for (int i = 1; i <= 40 && nChanges < 2; i++) begin
      tick();
      if (dut.w_phase_raw !== prevPhase) begin
        prevPhase = dut.w_phase_raw;
        nChanges++;
        if (nChanges == 1) t1 = i;
        else               t2 = i;
      end
    end
    checkOutput("phase_changes", 32'(nChanges), 32'd2);
    checkOutput("phase_half_period", 32'(t2 - t1), 32'd4);

    waitMidFrame();
    applyStimulus(8'hE0);
    applyStimulus(8'h2B);
    applyStimulus(8'hF0);
    applyStimulus(8'h2B);
    waitCommit();
    checkOutput("ext_make_ignored", 32'(flashEn), 32'd0);

    waitRaster("wait_fs_cycle", 1, 0);
    checkOutput("fs_coincident", 32'(frameStart), 32'd1);
    driveByte(8'h76);
    checkOutput("coincident_inv_kept", 32'(invMask), 32'd5);
    checkOutput("coincident_rate_kept", 32'(rateSel), 32'd2);
    checkOutput("coincident_p_rate", 32'(dut.r_p_rate), 32'd0);
    applyStimulus(8'hF0);
    applyStimulus(8'h76);
    waitCommit();
    checkOutput("late_clear_inv", 32'(invMask), 32'd0);
    checkOutput("late_clear_rate", 32'(rateSel), 32'd0);

    waitMidFrame();
    applyStimulus(8'hF0);
    rst_n = 1'b0;
    tick();
    tick();
    checkOutput("midrst_fs", 32'(frameStart), 32'd0);
    checkOutput("midrst_state", 32'(dut.r_state), 32'd0);
    rst_n = 1'b1;
    tick();
    applyStimulus(8'h2B);
    applyStimulus(8'hF0);
    applyStimulus(8'h2B);
    waitCommit();
    checkOutput("flash_after_reset", 32'(flashEn), 32'd1);

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
